// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: merges ALU, FPU and buffered load results into one registered
// register-file write port. Define WB_FWD_EN to add a combinational forward of the current grant.
`ifndef WIDTH
`define WIDTH 32
`endif

module reg_wb_arbiter (
  input  logic              clk,
  input  logic              rstn,
  input  logic              alu_valid,
  input  logic              alu_gfflag,
  input  logic [4:0]        alu_num,
  input  logic [`WIDTH-1:0] alu_data,
  output logic              alu_ready,
  input  logic              fpu_valid,
  input  logic              fpu_gfflag,
  input  logic [4:0]        fpu_num,
  input  logic [`WIDTH-1:0] fpu_data,
  output logic              fpu_ready,
  input  logic              mem_valid,
  input  logic              mem_gfflag,
  input  logic [4:0]        mem_num,
  input  logic [`WIDTH-1:0] mem_data,
  output logic              mem_stall,
  output logic              enable,
  output logic              r_gfflag,
  output logic [4:0]        r_num,
  output logic [`WIDTH-1:0] r_data,
  output logic              err_overflow
`ifdef WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic              fwd_gfflag,
  output logic [4:0]        fwd_num,
  output logic [`WIDTH-1:0] fwd_data
`endif
);

  localparam int EW = `WIDTH + 6;

  logic [EW-1:0]     fifo_mem [4];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        count;
  logic [EW-1:0]     head;
  logic              fifo_grant;
  logic              fpu_grant;
  logic              alu_grant;
  logic              grant;
  logic              sel_gfflag;
  logic [4:0]        sel_num;
  logic [`WIDTH-1:0] sel_data;
  logic              reg_zero;
  logic              write_ok;
  logic              push;
  logic              pop;
  logic              overflow_hit;

  assign head       = fifo_mem[rd_ptr];
  assign fpu_ready  = (count == 3'd0);
  assign alu_ready  = (count == 3'd0) && !fpu_valid;
  assign mem_stall  = (count >= 3'd3);

  // The FIFO head always wins, so a non-empty FIFO pops every cycle.
  assign fifo_grant = (count != 3'd0);
  assign fpu_grant  = fpu_valid && fpu_ready;
  assign alu_grant  = alu_valid && alu_ready;
  assign grant      = fifo_grant || fpu_grant || alu_grant;

  always_comb begin
    sel_gfflag = 1'b0;
    sel_num    = 5'd0;
    sel_data   = '0;
    if (fifo_grant) begin
      sel_gfflag = head[EW-1];
      sel_num    = head[EW-2 -: 5];
      sel_data   = head[`WIDTH-1:0];
    end else if (fpu_grant) begin
      sel_gfflag = fpu_gfflag;
      sel_num    = fpu_num;
      sel_data   = fpu_data;
    end else if (alu_grant) begin
      sel_gfflag = alu_gfflag;
      sel_num    = alu_num;
      sel_data   = alu_data;
    end
  end

  // General register 0 is hardwired; its writes are consumed but never enabled.
  assign reg_zero     = !sel_gfflag && (sel_num == 5'd0);
  assign write_ok     = grant && !reg_zero;

  assign pop          = fifo_grant;
  assign push         = mem_valid && (count != 3'd4);
  assign overflow_hit = mem_valid && (count == 3'd4);

`ifdef WB_FWD_EN
  assign fwd_valid  = write_ok;
  assign fwd_gfflag = sel_gfflag;
  assign fwd_num    = sel_num;
  assign fwd_data   = sel_data;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {mem_gfflag, mem_num, mem_data};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr       <= 2'd0;
      rd_ptr       <= 2'd0;
      count        <= 3'd0;
      err_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      count <= count + {2'b00, push} - {2'b00, pop};
      if (overflow_hit) begin
        err_overflow <= 1'b1;
      end
    end
  end

  // Write-port fields hold their last granted value when nothing is granted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      enable   <= 1'b0;
      r_gfflag <= 1'b0;
      r_num    <= 5'd0;
      r_data   <= '0;
    end else begin
      enable <= write_ok;
      if (grant) begin
        r_gfflag <= sel_gfflag;
        r_num    <= sel_num;
        r_data   <= sel_data;
      end
    end
  end

endmodule
